// File: rtl/alarm_unit.sv
// Alarm unit: alarm time setting, match/fire detection and the
// IDLE/ARMED/RINGING/SNOOZE controller driving the Ring indicator.
// Optional build macro ALARM_BLINK_EN: Ring blinks in RINGING with a
// period of 2*BLINK_DIV Clk cycles; when undefined, Ring is a steady 1.
module alarm_unit #(
  parameter int unsigned RING_SECS  = 60,
  parameter int unsigned SNOOZE_MIN = 5,
  parameter int unsigned BLINK_DIV  = 25
) (
  input  logic       Clk,
  input  logic       reset,
  input  logic [3:0] Hrs1,
  input  logic [3:0] Hrs0,
  input  logic [3:0] Min1,
  input  logic [3:0] Min0,
  input  logic [3:0] Sec1,
  input  logic [3:0] Sec0,
  input  logic [3:0] AP,
  input  logic       Arm,
  input  logic       Set_en,
  input  logic       Inc_hr,
  input  logic       Inc_min,
  input  logic       Snooze,
  input  logic       Stop,
  output logic [3:0] AHr1,
  output logic [3:0] AHr0,
  output logic [3:0] AMi1,
  output logic [3:0] AMi0,
  output logic [3:0] AAP,
  output logic       Ring,
  output logic [1:0] State
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    RINGING = 2'd2,
    SNOOZE  = 2'd3
  } state_t;

  localparam logic [7:0] RING_LD = 8'(RING_SECS);
  localparam logic [3:0] SNZ_LD  = 4'(SNOOZE_MIN);
  localparam logic [3:0] AM_CODE = 4'd10;
  localparam logic [3:0] PM_CODE = 4'd11;

  state_t     state;
  logic [4:0] hr_idx;     // 0..23, 0 = 00A, 12 = 12P, 23 = 11P
  logic [3:0] mi1, mi0;
  logic [7:0] ring_cnt;
  logic [3:0] snz_cnt;
  logic       ring_q;
  logic [3:0] sec0_q, min0_q;
  logic       match_q, match_qq;

  logic       match_now, fire, sec_tick, min_tick;
  logic [4:0] hv, hv_m10;
  logic [3:0] aap;

`ifdef ALARM_BLINK_EN
  localparam logic [15:0] DIV_LAST = 16'(BLINK_DIV - 1);
  logic [15:0] blink_div;
`endif

  // Hour index to 12-hour BCD display plus half-day code
  always_comb begin
    hv  = hr_idx;
    aap = AM_CODE;
    if (hr_idx >= 5'd12) begin
      aap = PM_CODE;
      hv  = (hr_idx == 5'd12) ? 5'd12 : hr_idx - 5'd12;
    end
    hv_m10 = hv - 5'd10;
  end

  assign AHr1  = (hv >= 5'd10) ? 4'd1 : 4'd0;
  assign AHr0  = (hv >= 5'd10) ? hv_m10[3:0] : hv[3:0];
  assign AMi1  = mi1;
  assign AMi0  = mi0;
  assign AAP   = aap;
  assign Ring  = ring_q;
  assign State = state;

  assign match_now = (Hrs1 == AHr1) && (Hrs0 == AHr0) &&
                     (Min1 == AMi1) && (Min0 == AMi0) && (AP == AAP) &&
                     (Sec1 == 4'd0) && (Sec0 == 4'd0);
  // Fire only on the rising edge of the registered match
  assign fire     = match_q & ~match_qq;
  assign sec_tick = (Sec0 != sec0_q);
  assign min_tick = (Min0 != min0_q);

  // Input samples for tick and match-edge detection; reset loads them
  // from the live inputs so nothing fires right after reset
  always_ff @(posedge Clk) begin
    sec0_q   <= Sec0;
    min0_q   <= Min0;
    match_q  <= match_now;
    match_qq <= reset ? match_now : match_q;
  end

  // Alarm setting: hour and minute stepping in set mode, no carry
  always_ff @(posedge Clk) begin
    if (reset) begin
      hr_idx <= 5'd6;
      mi1    <= 4'd0;
      mi0    <= 4'd0;
    end else if (Set_en) begin
      if (Inc_hr)
        hr_idx <= (hr_idx == 5'd23) ? 5'd0 : hr_idx + 5'd1;
      if (Inc_min) begin
        if (mi0 == 4'd9) begin
          mi0 <= 4'd0;
          mi1 <= (mi1 == 4'd5) ? 4'd0 : mi1 + 4'd1;
        end else begin
          mi0 <= mi0 + 4'd1;
        end
      end
    end
  end

  // Alarm controller with registered Ring output
  always_ff @(posedge Clk) begin
    if (reset) begin
      state    <= IDLE;
      ring_q   <= 1'b0;
      ring_cnt <= 8'd0;
      snz_cnt  <= 4'd0;
`ifdef ALARM_BLINK_EN
      blink_div <= 16'd0;
`endif
    end else if (!Arm) begin
      state  <= IDLE;
      ring_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ring_q <= 1'b0;
          if (!Set_en) state <= ARMED;
        end
        ARMED: begin
          ring_q <= 1'b0;
          if (fire && !Set_en) begin
            state    <= RINGING;
            ring_cnt <= RING_LD;
            ring_q   <= 1'b1;
`ifdef ALARM_BLINK_EN
            blink_div <= 16'd0;
`endif
          end
        end
        RINGING: begin
          if (Set_en || Stop) begin
            state  <= ARMED;
            ring_q <= 1'b0;
          end else if (Snooze) begin
            state   <= SNOOZE;
            snz_cnt <= SNZ_LD;
            ring_q  <= 1'b0;
          end else if (sec_tick && ring_cnt <= 8'd1) begin
            state    <= ARMED;
            ring_cnt <= 8'd0;
            ring_q   <= 1'b0;
          end else begin
            if (sec_tick) ring_cnt <= ring_cnt - 8'd1;
`ifdef ALARM_BLINK_EN
            if (blink_div == DIV_LAST) begin
              blink_div <= 16'd0;
              ring_q    <= ~ring_q;
            end else begin
              blink_div <= blink_div + 16'd1;
            end
`else
            ring_q <= 1'b1;
`endif
          end
        end
        SNOOZE: begin
          ring_q <= 1'b0;
          if (Set_en || Stop) begin
            state <= ARMED;
          end else if (min_tick) begin
            if (snz_cnt <= 4'd1) begin
              snz_cnt  <= 4'd0;
              state    <= RINGING;
              ring_cnt <= RING_LD;
              ring_q   <= 1'b1;
`ifdef ALARM_BLINK_EN
              blink_div <= 16'd0;
`endif
            end else begin
              snz_cnt <= snz_cnt - 4'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alarm_unit.sv
// Directed bench for alarm_unit: reset, fire, auto-stop, snooze, set-mode
// override, arm-off, reset mid-ring, Ring pattern and alarm setting.
module tb_alarm_unit;

  logic       Clk = 1'b0;
  logic       reset;
  logic [3:0] Hrs1, Hrs0, Min1, Min0, Sec1, Sec0, AP;
  logic       Arm, Set_en, Inc_hr, Inc_min, Snooze, Stop;
  logic [3:0] AHr1, AHr0, AMi1, AMi0, AAP;
  logic       Ring;
  logic [1:0] State;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef ALARM_BLINK_EN
  localparam int unsigned BDIV = 4;
`else
  localparam int unsigned BDIV = 25;
`endif

  alarm_unit #(.RING_SECS(60), .SNOOZE_MIN(5), .BLINK_DIV(BDIV)) dut (
    .Clk(Clk), .reset(reset),
    .Hrs1(Hrs1), .Hrs0(Hrs0), .Min1(Min1), .Min0(Min0), .Sec1(Sec1), .Sec0(Sec0),
    .AP(AP), .Arm(Arm), .Set_en(Set_en), .Inc_hr(Inc_hr), .Inc_min(Inc_min),
    .Snooze(Snooze), .Stop(Stop),
    .AHr1(AHr1), .AHr0(AHr0), .AMi1(AMi1), .AMi0(AMi0), .AAP(AAP),
    .Ring(Ring), .State(State)
  );

  always #5 Clk = ~Clk;

  // Advance n rising edges, then park on the falling edge to sample/drive
  task automatic step(input int n);
    repeat (n) @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic set_time(input logic [3:0] h1, h0, m1, m0, s1, s0, ap);
    Hrs1 = h1; Hrs0 = h0; Min1 = m1; Min0 = m0; Sec1 = s1; Sec0 = s0; AP = ap;
  endtask

  // Move time off and back onto 06:00:00 AM; returns at the first Ring=1 cycle
  task automatic ring_up(output logic ok);
    ok = 1'b0;
    set_time(0, 6, 0, 1, 0, 0, 10);
    step(2);
    Min0 = 4'd0;
    for (int i = 0; i < 5 && !ok; i++) begin
      step(1);
      if (Ring === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; Arm = 1'b0; Set_en = 1'b0; Inc_hr = 1'b0; Inc_min = 1'b0;
    Snooze = 1'b0; Stop = 1'b0;
    set_time(0, 5, 5, 9, 5, 9, 10);
    step(1);
    n_checks++;
    if ({State, Ring} !== 3'b000) begin
      n_fail++; $display("FAIL reset_state: State=%0d Ring=%b, want 0/0", State, Ring);
    end
    n_checks++;
    if ({AHr1, AHr0, AMi1, AMi0, AAP} !== {4'd0, 4'd6, 4'd0, 4'd0, 4'd10}) begin
      n_fail++; $display("FAIL reset_alarm: %0d%0d:%0d%0d ap=%0d, want 06:00 ap=10",
                         AHr1, AHr0, AMi1, AMi0, AAP);
    end
    reset = 1'b0;
  endtask

  task automatic test_fire;
    logic ok;
    Arm = 1'b1;
    step(1);
    n_checks++;
    if (State !== 2'd1) begin
      n_fail++; $display("FAIL idle_to_armed: State=%0d, want 1", State);
    end
    step(2);
    set_time(0, 6, 0, 0, 0, 0, 10);
    ok = 1'b0;
    for (int i = 0; i < 4 && !ok; i++) begin
      step(1);
      if (Ring === 1'b1) ok = 1'b1;
    end
    n_checks++;
    if (!ok || State !== 2'd2) begin
      n_fail++; $display("FAIL fire: Ring=%b State=%0d, want 1/2", Ring, State);
    end
  endtask

  task automatic test_timeout;
    Sec1 = 4'd1;
    for (int i = 1; i < 60; i++) begin
      Sec0 = 4'(i % 10);
      step(1);
    end
    n_checks++;
    if ({State, Ring} !== 3'b101) begin
      n_fail++; $display("FAIL tick59: State=%0d Ring=%b, want 2/1", State, Ring);
    end
    Sec0 = 4'd0;
    step(1);
    n_checks++;
    if ({State, Ring} !== 3'b010) begin
      n_fail++; $display("FAIL tick60: State=%0d Ring=%b, want 1/0", State, Ring);
    end
    Sec1 = 4'd3;
    step(3);
    n_checks++;
    if ({State, Ring} !== 3'b010) begin
      n_fail++; $display("FAIL no_refire: State=%0d Ring=%b, want 1/0", State, Ring);
    end
  endtask

  task automatic test_snooze;
    logic ok;
    ring_up(ok);
    Snooze = 1'b1; Stop = 1'b1;
    step(1);
    Snooze = 1'b0; Stop = 1'b0;
    n_checks++;
    if (!ok || {State, Ring} !== 3'b010) begin
      n_fail++; $display("FAIL stop_wins: ok=%b State=%0d Ring=%b, want 1/1/0", ok, State, Ring);
    end
    ring_up(ok);
    Snooze = 1'b1;
    step(1);
    Snooze = 1'b0;
    n_checks++;
    if (!ok || {State, Ring} !== 3'b110) begin
      n_fail++; $display("FAIL snooze: ok=%b State=%0d Ring=%b, want 1/3/0", ok, State, Ring);
    end
    for (int i = 1; i < 5; i++) begin
      Min0 = 4'(i);
      step(1);
    end
    n_checks++;
    if ({State, Ring} !== 3'b110) begin
      n_fail++; $display("FAIL snooze_4ticks: State=%0d Ring=%b, want 3/0", State, Ring);
    end
    Min0 = 4'd5;
    step(1);
    n_checks++;
    if ({State, Ring} !== 3'b101) begin
      n_fail++; $display("FAIL snooze_5ticks: State=%0d Ring=%b, want 2/1", State, Ring);
    end
  endtask

  task automatic test_set_override;
    Set_en = 1'b1;
    step(1);
    n_checks++;
    if ({State, Ring} !== 3'b010) begin
      n_fail++; $display("FAIL set_forces_armed: State=%0d Ring=%b, want 1/0", State, Ring);
    end
    set_time(0, 6, 0, 1, 0, 0, 10);
    step(2);
    Min0 = 4'd0;
    step(3);
    Set_en = 1'b0;
    step(3);
    n_checks++;
    if ({State, Ring} !== 3'b010) begin
      n_fail++; $display("FAIL fire_lost: State=%0d Ring=%b, want 1/0", State, Ring);
    end
  endtask

  task automatic test_arm_off;
    logic ok;
    ring_up(ok);
    Snooze = 1'b1;
    step(1);
    Snooze = 1'b0;
    Arm = 1'b0;
    step(1);
    n_checks++;
    if (!ok || {State, Ring} !== 3'b000) begin
      n_fail++; $display("FAIL arm_off: ok=%b State=%0d Ring=%b, want 1/0/0", ok, State, Ring);
    end
    Arm = 1'b1;
    step(1);
  endtask

  task automatic test_reset_ring;
    logic ok;
    ring_up(ok);
    reset = 1'b1;
    step(1);
    n_checks++;
    if (!ok || {State, Ring} !== 3'b000 || {AHr0, AAP} !== {4'd6, 4'd10}) begin
      n_fail++; $display("FAIL reset_ring: ok=%b State=%0d Ring=%b hr0=%0d ap=%0d, want 1/0/0/6/10",
                         ok, State, Ring, AHr0, AAP);
    end
    reset = 1'b0;
    step(1);
  endtask

  task automatic test_ring_pattern;
    logic       ok;
    logic [8:0] exp_pat, got_pat;
`ifdef ALARM_BLINK_EN
    exp_pat = 9'b1_0000_1111;
`else
    exp_pat = 9'b1_1111_1111;
`endif
    ring_up(ok);
    got_pat = '0;
    for (int i = 0; i < 9; i++) begin
      got_pat[i] = Ring;
      if (i < 8) step(1);
    end
    n_checks++;
    if (!ok || got_pat !== exp_pat || State !== 2'd2) begin
      n_fail++; $display("FAIL ring_pattern: ok=%b got=%b State=%0d, want 1/%b/2",
                         ok, got_pat, State, exp_pat);
    end
    Stop = 1'b1;
    step(1);
    Stop = 1'b0;
  endtask

  task automatic test_alarm_set;
    Set_en = 1'b1;
    Inc_hr = 1'b1;
    step(6);
    Inc_hr = 1'b0;
    n_checks++;
    if ({AHr1, AHr0, AAP} !== {4'd1, 4'd2, 4'd11}) begin
      n_fail++; $display("FAIL hr_12p: %0d%0d ap=%0d, want 12 ap=11", AHr1, AHr0, AAP);
    end
    Inc_hr = 1'b1;
    step(7);
    Inc_hr = 1'b0;
    n_checks++;
    if ({AHr1, AHr0, AAP} !== {4'd0, 4'd7, 4'd11}) begin
      n_fail++; $display("FAIL hr_07p: %0d%0d ap=%0d, want 07 ap=11", AHr1, AHr0, AAP);
    end
    Inc_min = 1'b1;
    step(60);
    n_checks++;
    if ({AMi1, AMi0, AHr0} !== {4'd0, 4'd0, 4'd7}) begin
      n_fail++; $display("FAIL min_wrap: %0d%0d hr0=%0d, want 00 hr0=7", AMi1, AMi0, AHr0);
    end
    step(1);
    Inc_min = 1'b0;
    n_checks++;
    if ({AMi1, AMi0} !== {4'd0, 4'd1}) begin
      n_fail++; $display("FAIL min_61: %0d%0d, want 01", AMi1, AMi0);
    end
    Inc_hr = 1'b1;
    step(24);
    Inc_hr = 1'b0;
    n_checks++;
    if ({AHr1, AHr0, AAP} !== {4'd0, 4'd7, 4'd11}) begin
      n_fail++; $display("FAIL hr_24: %0d%0d ap=%0d, want 07 ap=11", AHr1, AHr0, AAP);
    end
    Inc_hr = 1'b1; Inc_min = 1'b1;
    step(1);
    n_checks++;
    if ({AHr0, AAP, AMi0} !== {4'd8, 4'd11, 4'd2}) begin
      n_fail++; $display("FAIL both_inc: hr0=%0d ap=%0d mi0=%0d, want 8/11/2", AHr0, AAP, AMi0);
    end
    Set_en = 1'b0;
    step(2);
    n_checks++;
    if ({AHr0, AAP, AMi0} !== {4'd8, 4'd11, 4'd2}) begin
      n_fail++; $display("FAIL inc_ignored: hr0=%0d ap=%0d mi0=%0d, want 8/11/2", AHr0, AAP, AMi0);
    end
    Inc_min = 1'b0;
    Set_en = 1'b1;
    step(4);
    Inc_hr = 1'b0;
    Set_en = 1'b0;
    n_checks++;
    if ({AHr1, AHr0, AAP} !== {4'd0, 4'd0, 4'd10}) begin
      n_fail++; $display("FAIL hr_wrap_00a: %0d%0d ap=%0d, want 00 ap=10", AHr1, AHr0, AAP);
    end
  endtask

  initial begin
    test_reset;
    test_fire;
    test_timeout;
    test_snooze;
    test_set_override;
    test_arm_off;
    test_reset_ring;
    test_ring_pattern;
    test_alarm_set;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
